// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  // Who owns the response slot in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int          WORD_BYTES = 4;
  localparam int          WORD_SHIFT = $clog2(WORD_BYTES);
  localparam logic [3:0]  FETCH_BE   = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between core (fetch + LSU), arbiter and unified RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 10
);
  // fetch port
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  // load/store port
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  // memory macro port
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Core + memory view.
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Counts consecutive denied fetch cycles; flags starvation at MAX_WAIT.
module arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic req,
  input  logic gnt,
  output logic starved
);
  localparam int            CW    = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CMAX  = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;

  // Saturating count of denied cycles; any grant or dropped request clears it.
  always_ff @(posedge clk) begin
    if (!n_rst)             r_cnt <= '0;
    else if (req && !gnt) begin
      if (r_cnt != CMAX)    r_cnt <= r_cnt + 1'b1;
    end else                r_cnt <= '0;
  end

  assign starved = (r_cnt == CMAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port arbiter: data beats fetch unless fetch has starved MAX_WAIT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  mem_arbiter_if.slave  io_bus
);

  logic              w_starved;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [3:0]        w_mem_be;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [31:0]       w_mem_wdata;
  owner_t            r_owner;

  arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk     (clk),
    .n_rst   (n_rst),
    .req     (io_bus.if_req),
    .gnt     (w_if_gnt),
    .starved (w_starved)
  );

  // Priority: starved fetch > data > fetch; nothing is granted while in reset.
  always_comb begin
    w_if_gnt = n_rst && io_bus.if_req && (w_starved || !io_bus.d_req);
    w_d_gnt  = n_rst && io_bus.d_req  && !w_if_gnt;
  end

  // Winner drives the RAM this cycle; idle cycles drive all zeros.
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_be    = '0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_if_gnt) begin
      w_mem_en   = 1'b1;
      w_mem_be   = FETCH_BE;
      w_mem_addr = io_bus.if_addr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
    end else if (w_d_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = io_bus.d_we;
      w_mem_be    = io_bus.d_be;
      w_mem_addr  = io_bus.d_addr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
      w_mem_wdata = io_bus.d_wdata;
    end
  end

  // Remember this cycle's winner so next cycle's RAM output goes to it.
  always_ff @(posedge clk) begin
    if (!n_rst)        r_owner <= OWN_NONE;
    else if (w_if_gnt) r_owner <= OWN_IF;
    else if (w_d_gnt)  r_owner <= OWN_D;
    else               r_owner <= OWN_NONE;
  end

  assign io_bus.if_gnt    = w_if_gnt;
  assign io_bus.d_gnt     = w_d_gnt;
  assign io_bus.mem_en    = w_mem_en;
  assign io_bus.mem_we    = w_mem_we;
  assign io_bus.mem_be    = w_mem_be;
  assign io_bus.mem_addr  = w_mem_addr;
  assign io_bus.mem_wdata = w_mem_wdata;
  // A response due in a cycle where reset is asserted is squashed.
  assign io_bus.if_rvalid = n_rst && (r_owner == OWN_IF);
  assign io_bus.d_rvalid  = n_rst && (r_owner == OWN_D);
  assign io_bus.if_rdata  = io_bus.mem_rdata;
  assign io_bus.d_rdata   = io_bus.mem_rdata;

  // Byte-offset and out-of-range address bits are deliberately ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^{io_bus.if_addr[31:ADDR_W+WORD_SHIFT], io_bus.if_addr[WORD_SHIFT-1:0],
                           io_bus.d_addr[31:ADDR_W+WORD_SHIFT],  io_bus.d_addr[WORD_SHIFT-1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: reference model predicts grants/responses,
// monitor matches responses as the DUT presents them.
module tb_mem_arbiter;
  localparam int ADDR_W   = 10;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] PRELOAD = 32'h00A00093;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .io_bus (bus)
  );

  typedef struct {
    bit          is_if;
    bit          rd;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          g_if     = 0;   // model's grant decision this cycle
  bit          g_d      = 0;
  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  bit          ram_init = 0;
  bit          ref_init = 0;
  int          m_wait   = 0;   // consecutive denied fetch cycles

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [ADDR_W-1:0] widx(input logic [31:0] a);
    int unsigned w;
    w = (a / 4) % DEPTH;
    return ADDR_W'(w);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory macro: synchronous RAM, one-cycle read latency, byte-enabled write.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= (i == 2) ? PRELOAD : 32'h0;
      ram_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  // Reference model: decides the winner from spec rules and queues the response.
  always @(negedge clk) begin
    logic [31:0] w;
    logic [ADDR_W-1:0] ea;
    if (!ref_init) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i == 2) ? PRELOAD : 32'h0;
      ref_init = 1;
    end
    g_if = 0;
    g_d  = 0;
    if (!n_rst) begin
      chk("reset_quiet", {bus.if_gnt, bus.d_gnt, bus.mem_en}, 3'b000);
      m_wait = 0;
    end else begin
      g_if = bus.if_req && (m_wait >= MAX_WAIT || !bus.d_req);
      g_d  = bus.d_req && !g_if;
      if (g_if) begin
        ea = widx(bus.if_addr);
        chk("fetch_drive", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr},
            {3'b101, 1'b0, 4'hF, ea});
        sb.push_back('{is_if: 1, rd: 1, data: ref_mem[ea], due: cyc + 1});
      end else if (g_d) begin
        ea = widx(bus.d_addr);
        chk("data_drive", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr},
            {3'b011, bus.d_we, bus.d_be, ea});
        if (bus.d_we) begin
          chk("store_wdata", bus.mem_wdata, bus.d_wdata);
          w = ref_mem[ea];
          for (int b = 0; b < 4; b++) if (bus.d_be[b]) w[8*b +: 8] = bus.d_wdata[8*b +: 8];
          ref_mem[ea] = w;
        end
        sb.push_back('{is_if: 0, rd: !bus.d_we, data: ref_mem[ea], due: cyc + 1});
      end else begin
        chk("idle_drive", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr},
            '0);
      end
      if (bus.if_req && !g_if) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else                     m_wait = 0;
    end
  end

  // Monitor: matches rvalids against the scoreboard queue.
  always @(negedge clk) begin
    resp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      chk("resp_timeout", 1, 0);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (!n_rst) begin
        chk("reset_squash", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
      end else begin
        chk("rvalid_route", {bus.if_rvalid, bus.d_rvalid}, e.is_if ? 2'b10 : 2'b01);
        if (e.rd) chk(e.is_if ? "if_rdata" : "d_rdata",
                      e.is_if ? bus.if_rdata : bus.d_rdata, e.data);
      end
    end else begin
      chk("no_rvalid", {bus.if_rvalid, bus.d_rvalid}, 2'b00);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic dreq(input bit we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    bus.d_req = 1; bus.d_we = we; bus.d_be = be; bus.d_addr = a; bus.d_wdata = wd;
  endtask

  initial begin
    logic [9:0] pat;
    idle();
    n_rst = 0;
    step();

    // Reset held with both requesters active, then data wins first.
    bus.if_req = 1; bus.if_addr = 32'h8;
    dreq(0, 4'hF, 32'h0, 32'h0);
    repeat (2) step();
    n_rst = 1;
    step();

    // Fetch only from 0x8 -> word 2, preloaded instruction.
    idle();
    bus.if_req = 1; bus.if_addr = 32'h8;
    step();
    idle();
    step();

    // Store 0x64 to 0x0 then load it back.
    dreq(1, 4'hF, 32'h0, 32'h64);
    step();
    dreq(0, 4'hF, 32'h0, 32'h0);
    step();
    idle();
    step();

    // Contention: fetch must win every MAX_WAIT+1 cycles.
    bus.if_req = 1; bus.if_addr = 32'h8;
    dreq(0, 4'hF, 32'h0, 32'h0);
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[i] = bus.if_gnt;
      step();
    end
    chk("contention_pattern", pat, 10'h210);
    idle();
    step();

    // Address wrap: 0x1004 lands on word 1.
    dreq(0, 4'hF, 32'h1004, 32'h0);
    @(negedge clk);
    chk("wrap_addr", bus.mem_addr, 1);
    step();
    idle();
    step();

    // Reset asserted the cycle after a load grant squashes its response.
    dreq(0, 4'hF, 32'h0, 32'h0);
    step();
    idle();
    n_rst = 0;
    step();
    n_rst = 1;
    step();
    step();

    // Randomized traffic with occasional drops and resets.
    for (int i = 0; i < 600; i++) begin
      n_rst = ($urandom_range(0, 59) != 0);
      if (!bus.if_req || g_if || $urandom_range(0, 9) == 0) begin
        bus.if_req  = ($urandom_range(0, 2) != 0);
        bus.if_addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                      | 32'($urandom_range(0, 3));
      end
      if (!bus.d_req || g_d || $urandom_range(0, 9) == 0) begin
        bus.d_req   = ($urandom_range(0, 1) != 0);
        bus.d_we    = ($urandom_range(0, 1) != 0);
        bus.d_be    = 4'($urandom);
        bus.d_addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                      | 32'($urandom_range(0, 3));
        bus.d_wdata = $urandom;
      end
      step();
    end

    n_rst = 1;
    idle();
    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
